dmem_block_store: RTL
=====================

# dmem_block_store

Block-granular data memory that sits directly downstream of the data cache and serves its refill and write-back traffic. It stores 128-bit blocks addressed by a 28-bit block address and models a fixed multi-cycle access latency. A `busywait` handshake stalls the cache controller until a block read or write completes. It is the unit the cache instantiates as its backing store.

## Interface
- `DEPTH`, 256: number of 128-bit blocks stored; must be a power of two.
- `LATENCY`, 5: number of BUSY cycles per access; must be ≥ 1.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `read` in 1: block read request; held high by the cache until `busywait` is seen low.
- `write` in 1: block write request; same holding rule as `read`.
- `address` in 28: block address (byte address [31:4]).
- `writedata` in 128: block to write; word 0 is in [31:0].
- `readdata` out 128: block read; registered.
- `busywait` out 1: high while a request is outstanding and not yet complete.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - BUSY: access in progress, latency counting.
  - DONE: one cycle, access complete.
- Array index is `address[log2(DEPTH)-1:0]`. Upper address bits are ignored, so addresses alias modulo DEPTH.
- IDLE:
  - `busywait = read | write` (combinational).
  - A posedge with `read | write` high latches `address`, `writedata` and the operation, loads `cnt = LATENCY-1`, and moves to BUSY.
- BUSY:
  - `busywait = 1`.
  - Each posedge with `cnt != 0` decrements `cnt`.
  - A posedge with `cnt == 0` performs the access using the latched values and moves to DONE:
    - Read: `readdata <= array[idx]`.
    - Write: `array[idx] <= writedata`.
- DONE:
  - `busywait = 0`.
  - Unconditional transition to IDLE on the next posedge.
  - A request still high in DONE is not re-sampled. The next access starts only from IDLE.
- `read` and `write` both high: treated as a write. `readdata` is unchanged.
- Request dropped while in BUSY (both `read` and `write` low at a posedge): abort to IDLE with no array write and no `readdata` update.
- Request inputs changing while in BUSY: ignored, because latched values are used.
- Reset asserted (low):
  - State returns to IDLE immediately and `cnt` is set to 0.
  - `readdata` is reset to 0.
  - `busywait` follows the IDLE combinational rule.
  - Array contents are not cleared.
  - An in-flight write is discarded.

## Timing
- Request raised in cycle 0: `busywait` is high in cycle 0.
- Posedge ending cycle 0 enters BUSY.
- Busywait high cycles total `LATENCY+1`.
- Cycle `LATENCY+1` is DONE: `busywait` low and `readdata` valid.
- Cycle `LATENCY+2` is IDLE.
- `readdata` holds its value until the next completed read or a reset.
- Minimum spacing between the starts of two accesses is `LATENCY+2` cycles.
- Reset outputs: `readdata = 0`; `busywait = read | write` (0 when no request).

## Structure
- Shared package `dmem_pkg` contains:
  - state enum {IDLE, BUSY, DONE}, 2-bit encoding;
  - `BLOCK_W = 128`;
  - `BADDR_W = 28`;
  - default `LATENCY`.
- Sub-module `dmem_block_array` holds the storage:
  - DEPTH×128 register array;
  - one synchronous write port;
  - one synchronous read port into the `readdata` register.
- FSM, counter and request latches are in the top level.

## Test plan
- Reset, then read block 0x0000010 with default LATENCY=5 → `busywait` high exactly 6 cycles; `readdata` (array initialised by bench) valid in cycle 6; IDLE in cycle 7.
- Write 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D to 0x0000003, then read 0x0000003 → read returns the same 128 bits; first access gap is 7 cycles.
- Write 0x...AA to 0x0000105 (DEPTH=256), then read 0x0000005 → returns 0x...AA (aliasing).
- Write starts, then `write` drops after 2 BUSY cycles → return to IDLE; a later read of that block shows the old contents.
- `reset` pulsed low in the middle of a read → `readdata=0` and state IDLE within the reset cycle; after release, a held `read` is re-sampled and completes in 6 cycles.
- `read` and `write` both high to 0x0000007 with data 0x55…55 → performed as a write; `readdata` unchanged; a following read returns 0x55…55.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and sizes for the block-granular data memory.
package dmem_pkg;

  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned BADDR_W     = 28;
  localparam int unsigned DEF_LATENCY = 5;
  localparam int unsigned DEF_DEPTH   = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_block_array.sv
// Block storage: one synchronous write port, one synchronous read port into a
// reset-cleared read register. The storage itself is never cleared.
module dmem_block_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [IDX_W-1:0]   idx,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_block_store.sv
// Cache backing store: latches a block request, counts a fixed latency, then
// performs the access and signals completion by dropping busywait for one cycle.
module dmem_block_store
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [BADDR_W-1:0] address,
  input  logic [BLOCK_W-1:0] writedata,
  output logic [BLOCK_W-1:0] readdata,
  output logic               busywait
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic               is_write_q;
  logic               latch;
  logic               arr_we;
  logic               arr_re;
  logic               req;

  // Upper block-address bits alias onto the same entries.
  logic unused_addr;
  assign unused_addr = ^address[BADDR_W-1:IDX_W];

  assign req = read | write;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; a simultaneous read and write is taken as a write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else if (latch) begin
      idx_q      <= address[IDX_W-1:0];
      wdata_q    <= writedata;
      is_write_q <= write;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busywait = 1'b0;
    latch    = 1'b0;
    arr_we   = 1'b0;
    arr_re   = 1'b0;
    case (state_q)
      IDLE: begin
        busywait = req;
        if (req) begin
          latch   = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        // A dropped request abandons the access, even on its final cycle.
        if (!req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          arr_we  = is_write_q;
          arr_re  = !is_write_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  dmem_block_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (readdata)
  );

endmodule
